// File: rtl/psk_pkg.sv
// -----------------------------------------------------------------------------
// psk_pkg
// Shared definitions for the PSK transmit path (symbol serializer and phase
// mapper): FSM state encoding, a clog2 that never yields a zero-width counter,
// and the symbols-per-word derivation.
// -----------------------------------------------------------------------------
package psk_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } psk_state_e;

  // Counter width for a counter that must reach n-1; at least 1 bit so a
  // single-symbol word still gets a legal (constant-zero) counter.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned syms_per_word(input int unsigned data_width,
                                                input int unsigned bits_per_symbol);
    return data_width / bits_per_symbol;
  endfunction

endpackage

// File: rtl/psk_word_prefetch.sv
// -----------------------------------------------------------------------------
// psk_word_prefetch
// One-word prefetch register in front of the symbol shifter. Pops the
// show-ahead FIFO whenever the hold slot is free, so the next word is ready
// before the current one finishes.
//
// FIFO handshake: sample_i is valid whenever empty_i=0; asserting read_o in a
// cycle pops the head at the next rising edge, and the word on sample_i in
// that same cycle is the one taken. read_o is never raised while empty_i=1,
// while the hold slot is full, while enable_i=0 or while rst=1.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable_i        0 freezes the hold slot and blocks reads
//   empty_i         FIFO empty flag
//   sample_i        FIFO head word
//   consume_i       top takes the held word this cycle
//   bypass_i        top takes sample_i directly this cycle; a read in this
//                   cycle goes to the shifter instead of the hold slot
//   read_o          FIFO pop pulse
//   hold_o          held word
//   hold_valid_o    hold slot full
// -----------------------------------------------------------------------------
module psk_word_prefetch #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  consume_i,
  input  logic                  bypass_i,
  output logic                  read_o,
  output logic [DATA_WIDTH-1:0] hold_o,
  output logic                  hold_valid_o
);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;

  // rst gates the pop combinationally so no word is lost while held in reset.
  assign read_o = !rst && enable_i && !hold_valid_q && !empty_i;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (read_o && !bypass_i) begin
      hold_d       = sample_i;
      hold_valid_d = 1'b1;
    end else if (consume_i) begin
      // consume only happens with the slot full, so it never races a read
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign hold_o       = hold_q;
  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/psk_symbol_serializer.sv
// -----------------------------------------------------------------------------
// psk_symbol_serializer
// Serialises DATA_WIDTH-bit FIFO words into BITS_PER_SYMBOL-bit symbols, each
// held for CLKS_PER_SYMBOL enabled clocks, for the downstream phase mapper.
// A one-word prefetch (psk_word_prefetch) plus a same-cycle bypass keep
// back-to-back words gapless.
//
// Ports
//   clk, rst          clock, synchronous active-high reset (wins over enable)
//   enable_i          0 freezes all state; strobe/read/underrun forced 0
//   sample_i          FIFO head word, valid while empty_i=0
//   empty_i           FIFO empty
//   read_o            FIFO pop pulse (word taken in the same cycle)
//   symbol_o          current symbol (IDLE_SYMBOL when no data)
//   symbol_valid_o    1 while a data symbol is driven
//   symbol_strobe_o   pulse on the first clock of every data symbol
//   symb_clk_o        toggles on every word loaded into the shifter
//   underrun_o        pulse when a word ends with no next word available
//   state_o           debug view of the FSM state
// -----------------------------------------------------------------------------
module psk_symbol_serializer
  import psk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned BITS_PER_SYMBOL = 2,
  parameter int unsigned CLKS_PER_SYMBOL = 100,
  parameter bit          MSB_FIRST       = 1'b0,
  parameter int unsigned IDLE_SYMBOL     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic [DATA_WIDTH-1:0]      sample_i,
  input  logic                       empty_i,
  output logic                       read_o,
  output logic [BITS_PER_SYMBOL-1:0] symbol_o,
  output logic                       symbol_valid_o,
  output logic                       symbol_strobe_o,
  output logic                       symb_clk_o,
  output logic                       underrun_o,
  output psk_state_e                 state_o
);

  localparam int unsigned SYMS_PER_WORD = syms_per_word(DATA_WIDTH, BITS_PER_SYMBOL);
  localparam int unsigned CW            = safe_clog2(CLKS_PER_SYMBOL);
  localparam int unsigned SW            = safe_clog2(SYMS_PER_WORD);
  localparam logic [CW-1:0] CLK_LAST    = CW'(CLKS_PER_SYMBOL - 1);
  localparam logic [SW-1:0] SYM_LAST    = SW'(SYMS_PER_WORD - 1);
  localparam logic [BITS_PER_SYMBOL-1:0] IDLE_SYM = BITS_PER_SYMBOL'(IDLE_SYMBOL);

  if (((DATA_WIDTH % BITS_PER_SYMBOL) != 0) || (CLKS_PER_SYMBOL < 2)) begin : g_bad_params
    $error("psk_symbol_serializer: DATA_WIDTH must be a multiple of BITS_PER_SYMBOL and CLKS_PER_SYMBOL must be >= 2");
  end

  // The symbol on air is always the group at the "output end" of the shifter;
  // the shifter moves toward that end after each symbol.
  function automatic logic [BITS_PER_SYMBOL-1:0] lead_symbol(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w[DATA_WIDTH-1 -: BITS_PER_SYMBOL];
    else           return w[BITS_PER_SYMBOL-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w << BITS_PER_SYMBOL;
    else           return w >> BITS_PER_SYMBOL;
  endfunction

  psk_state_e                 state_q, state_d;
  logic [CW-1:0]              clk_cnt_q, clk_cnt_d;
  logic [SW-1:0]              sym_cnt_q, sym_cnt_d;
  logic [DATA_WIDTH-1:0]      shifter_q, shifter_d;
  logic [BITS_PER_SYMBOL-1:0] symbol_q, symbol_d;
  logic                       symbol_valid_q, symbol_valid_d;
  logic                       strobe_q, strobe_d;
  logic                       symb_clk_q, symb_clk_d;
  logic                       underrun_q, underrun_d;

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_word;
  logic                  consume;
  logic                  bypass;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_word;

  psk_word_prefetch #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prefetch (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .empty_i      (empty_i),
    .sample_i     (sample_i),
    .consume_i    (consume),
    .bypass_i     (bypass),
    .read_o       (read_o),
    .hold_o       (hold_word),
    .hold_valid_o (hold_valid)
  );

  always_comb begin
    state_d        = state_q;
    clk_cnt_d      = clk_cnt_q;
    sym_cnt_d      = sym_cnt_q;
    shifter_d      = shifter_q;
    symb_clk_d     = symb_clk_q;
    symbol_d       = symbol_q;
    symbol_valid_d = symbol_valid_q;
    strobe_d       = 1'b0;
    underrun_d     = 1'b0;
    load           = 1'b0;
    load_word      = '0;
    consume        = 1'b0;
    bypass         = 1'b0;

    if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_valid) begin
            load      = 1'b1;
            load_word = hold_word;
            consume   = 1'b1;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (clk_cnt_q == CLK_LAST) begin
            clk_cnt_d = '0;
            if (sym_cnt_q == SYM_LAST) begin
              sym_cnt_d = '0;
              if (hold_valid) begin
                load      = 1'b1;
                load_word = hold_word;
                consume   = 1'b1;
              end else if (!empty_i) begin
                // Hold slot is empty: the prefetch read in this cycle is
                // steered straight into the shifter to avoid a gap.
                load      = 1'b1;
                load_word = sample_i;
                bypass    = 1'b1;
              end else begin
                underrun_d = 1'b1;
                state_d    = ST_IDLE;
              end
            end else begin
              sym_cnt_d = sym_cnt_q + SW'(1);
              shifter_d = advance(shifter_q);
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (load) begin
        shifter_d  = load_word;
        clk_cnt_d  = '0;
        sym_cnt_d  = '0;
        symb_clk_d = ~symb_clk_q;
      end

      // Outputs are registered from the next state so they line up with the
      // symbol the counters describe after this edge.
      symbol_valid_d = (state_d == ST_RUN);
      symbol_d       = symbol_valid_d ? lead_symbol(shifter_d) : IDLE_SYM;
      strobe_d       = symbol_valid_d && (clk_cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      clk_cnt_q      <= '0;
      sym_cnt_q      <= '0;
      shifter_q      <= '0;
      symbol_q       <= IDLE_SYM;
      symbol_valid_q <= 1'b0;
      strobe_q       <= 1'b0;
      symb_clk_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_cnt_q      <= clk_cnt_d;
      sym_cnt_q      <= sym_cnt_d;
      shifter_q      <= shifter_d;
      symbol_q       <= symbol_d;
      symbol_valid_q <= symbol_valid_d;
      strobe_q       <= strobe_d;
      symb_clk_q     <= symb_clk_d;
      underrun_q     <= underrun_d;
    end
  end

  assign symbol_o        = symbol_q;
  assign symbol_valid_o  = symbol_valid_q;
  assign symbol_strobe_o = strobe_q;
  assign symb_clk_o      = symb_clk_q;
  assign underrun_o      = underrun_q;
  assign state_o         = state_q;

endmodule
